// File: rtl/if_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_pkg
// Description : Shared encodings for the instruction-fetch stage: next-PC
//               select codes, NOP word, reset PC default and FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package if_fetch_pkg;

    // Next-PC select codes driven by ID
    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    // Bubble word and default first fetch address
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Fetch FSM state encoding
    localparam logic [0:0] ST_REQ  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

endpackage
`default_nettype wire

// File: rtl/if_npc_sel.sv
`default_nettype none
// ============================================================================
// Module      : if_npc_sel
// Description : Combinational 4:1 next-PC target mux. Every target is forced
//               to word alignment by clearing bits [1:0].
// Revision    : 1.0 - initial release
// ============================================================================
module if_npc_sel
    import if_fetch_pkg::*;
(
    input  logic [1:0]  pcsrc,
    input  logic [31:0] pc4,
    input  logic [31:0] bpc,
    input  logic [31:0] ra,
    input  logic [31:0] jpc,
    output logic [31:0] target
);

    logic [31:0] w_raw;

    // Select the raw target, then word-align it
    always_comb begin
        w_raw = pc4;
        case (pcsrc)
            PCSRC_SEQ: w_raw = pc4;
            PCSRC_BR:  w_raw = bpc;
            PCSRC_JR:  w_raw = ra;
            PCSRC_J:   w_raw = jpc;
            default:   w_raw = pc4;
        endcase
    end

    assign target = {w_raw[31:2], 2'b00};

endmodule
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch
// Description : Instruction-fetch stage. Owns the PC, requests words from a
//               variable-latency instruction memory, inserts NOP bubbles while
//               memory is busy, buffers a word across a load-dependency stall
//               and remembers a delayed-branch redirect that arrives while
//               the delay slot is still being fetched.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP      = NOP_WORD
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        loaddepend,
    input  logic [1:0]  pcsrc,
    input  logic [31:0] bpc,
    input  logic [31:0] ra,
    input  logic [31:0] jpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc4,
    output logic        inst_valid
);

    localparam logic [31:0] C_RESET_PC4 = RESET_PC + 32'd4;

    logic [0:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_buf;
    logic        r_redir_pend;
    logic [31:0] r_redir_pc;

    logic [31:0] w_pc4;
    logic [31:0] w_tgt;
    logic        w_redirect;
    logic [31:0] w_npc;

    assign w_pc4 = r_pc + 32'd4;

    if_npc_sel u_npc_sel (
        .pcsrc  (pcsrc),
        .pc4    (w_pc4),
        .bpc    (bpc),
        .ra     (ra),
        .jpc    (jpc),
        .target (w_tgt)
    );

    // A redirect seen during a stall is dropped; ID re-presents it later.
    // A buffered redirect takes priority over anything ID shows now.
    assign w_redirect = (pcsrc != PCSRC_SEQ) && !loaddepend;
    assign w_npc      = r_redir_pend ? r_redir_pc :
                        w_redirect   ? w_tgt      : w_pc4;

    // Fetch FSM with PC, stall buffer and pending-redirect registers
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state      <= ST_REQ;
            r_pc         <= RESET_PC;
            r_buf        <= NOP;
            r_redir_pend <= 1'b0;
            r_redir_pc   <= RESET_PC;
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (imem_ack) begin
                        if (!loaddepend) begin
                            r_pc         <= w_npc;
                            r_redir_pend <= 1'b0;
                        end else begin
                            r_buf   <= imem_rdata;
                            r_state <= ST_HOLD;
                        end
                    end else if (w_redirect && !r_redir_pend) begin
                        // Branch leaves ID while its delay slot is in flight
                        r_redir_pend <= 1'b1;
                        r_redir_pc   <= w_tgt;
                    end
                end
                ST_HOLD: begin
                    if (!loaddepend) begin
                        r_pc         <= w_npc;
                        r_redir_pend <= 1'b0;
                        r_state      <= ST_REQ;
                    end
                end
                default: r_state <= ST_REQ;
            endcase
        end
    end

    // IF/ID-facing outputs straight from state and the memory response
    always_comb begin
        imem_req   = 1'b0;
        inst       = NOP;
        inst_valid = 1'b0;
        pc4        = C_RESET_PC4;
        if (!clr) begin
            pc4 = w_pc4;
            if (r_state == ST_REQ) begin
                imem_req   = 1'b1;
                inst_valid = imem_ack;
                inst       = imem_ack ? imem_rdata : NOP;
            end else begin
                inst_valid = 1'b1;
                inst       = r_buf;
            end
        end
    end

    assign imem_addr = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch
// Description : Directed self-checking bench for if_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

    logic        clk;
    logic        clr;
    logic        loaddepend;
    logic [1:0]  pcsrc;
    logic [31:0] bpc;
    logic [31:0] ra;
    logic [31:0] jpc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        inst_valid;

    int total;
    int bad;

    localparam logic [31:0] C_KEY = 32'hA5A5_0000;

    if_fetch dut (
        .clk        (clk),
        .clr        (clr),
        .loaddepend (loaddepend),
        .pcsrc      (pcsrc),
        .bpc        (bpc),
        .ra         (ra),
        .jpc        (jpc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .pc4        (pc4),
        .inst_valid (inst_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clr = 1'b1; loaddepend = 1'b0; pcsrc = 2'b00;
        bpc = '0; ra = '0; jpc = '0; imem_ack = 1'b0; imem_rdata = '0;
        cyc();
        cyc();

        // Reset state
        #1;
        chk("rst_req",   {31'd0, imem_req},   32'd0);
        chk("rst_inst",  inst,                32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_pc4",   pc4,                 32'd4);
        chk("rst_addr",  imem_addr,           32'd0);

        // 1: back-to-back single-cycle acks
        clr = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            imem_ack   = 1'b1;
            imem_rdata = (32'(i) * 32'd4) ^ C_KEY;
            #1;
            chk("seq_addr",  imem_addr,           32'(i) * 32'd4);
            chk("seq_req",   {31'd0, imem_req},   32'd1);
            chk("seq_inst",  inst,                (32'(i) * 32'd4) ^ C_KEY);
            chk("seq_valid", {31'd0, inst_valid}, 32'd1);
            chk("seq_pc4",   pc4,                 32'(i) * 32'd4 + 32'd4);
            cyc();
        end

        // 2: three-cycle ack latency at 0x10
        for (int i = 0; i < 2; i++) begin
            imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
            #1;
            chk("lat_addr",  imem_addr,           32'h10);
            chk("lat_inst",  inst,                32'd0);
            chk("lat_valid", {31'd0, inst_valid}, 32'd0);
            cyc();
        end
        imem_ack = 1'b1; imem_rdata = 32'h10 ^ C_KEY;
        #1;
        chk("lat_data",  inst,                32'hA5A5_0010);
        chk("lat_dval",  {31'd0, inst_valid}, 32'd1);
        cyc();

        // 3: load-dependency stall on the ack cycle at 0x14
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678; loaddepend = 1'b1;
        #1;
        chk("st_addr", imem_addr, 32'h14);
        chk("st_inst", inst,      32'h1234_5678);
        cyc();
        imem_ack = 1'b0; imem_rdata = 32'h0BAD_0BAD;
        #1;
        chk("hold_req",   {31'd0, imem_req},   32'd0);
        chk("hold_inst",  inst,                32'h1234_5678);
        chk("hold_valid", {31'd0, inst_valid}, 32'd1);
        chk("hold_pc4",   pc4,                 32'h18);
        cyc();
        loaddepend = 1'b0;
        #1;
        chk("rel_inst", inst,              32'h1234_5678);
        chk("rel_req",  {31'd0, imem_req}, 32'd0);
        cyc();
        #1;
        chk("rel_addr",    imem_addr,         32'h18);
        chk("rel_req_on",  {31'd0, imem_req}, 32'd1);

        // 4: branch with same-cycle ack; delay slot 0x18 delivered
        pcsrc = 2'b01; bpc = 32'h100; imem_ack = 1'b1; imem_rdata = 32'h0000_1818;
        #1;
        chk("br_slot", inst, 32'h0000_1818);
        cyc();
        pcsrc = 2'b00; imem_ack = 1'b0;
        #1;
        chk("br_addr", imem_addr, 32'h100);

        // 5: register-indirect redirect while the 0x100 fetch waits 4 cycles
        pcsrc = 2'b10; ra = 32'h203;
        #1;
        chk("jr_wait_valid", {31'd0, inst_valid}, 32'd0);
        cyc();
        pcsrc = 2'b00; ra = 32'h0;
        cyc();
        cyc();
        imem_ack = 1'b1; imem_rdata = 32'h0000_0100 ^ C_KEY;
        #1;
        chk("jr_slot_addr", imem_addr, 32'h100);
        chk("jr_slot",      inst,      32'hA5A5_0100);
        chk("jr_slot_pc4",  pc4,       32'h104);
        cyc();
        #1;
        chk("jr_addr", imem_addr, 32'h200);
        cyc();
        #1;
        chk("jr_clear", imem_addr, 32'h204);

        // Jump with unaligned target and PC wrap-around
        pcsrc = 2'b11; jpc = 32'hFFFF_FFFF;
        cyc();
        pcsrc = 2'b00;
        #1;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_pc4",  pc4,       32'h0);
        cyc();
        #1;
        chk("wrap_zero", imem_addr, 32'h0);

        // Redirect ignored under loaddepend
        imem_ack = 1'b0; loaddepend = 1'b1; pcsrc = 2'b01; bpc = 32'h300;
        cyc();
        loaddepend = 1'b0; pcsrc = 2'b00; imem_ack = 1'b1;
        cyc();
        #1;
        chk("ld_ign", imem_addr, 32'h4);

        // 6: reach 0x40, park a redirect mid-wait, then reset
        pcsrc = 2'b11; jpc = 32'h40;
        cyc();
        pcsrc = 2'b01; bpc = 32'h80; imem_ack = 1'b0;
        cyc();
        pcsrc = 2'b00;
        #1;
        chk("pre_clr_addr", imem_addr, 32'h40);
        clr = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hFEED_FACE;
        #1;
        chk("clr_req",   {31'd0, imem_req},   32'd0);
        chk("clr_inst",  inst,                32'd0);
        chk("clr_valid", {31'd0, inst_valid}, 32'd0);
        chk("clr_pc4",   pc4,                 32'd4);
        cyc();
        clr = 1'b0; imem_ack = 1'b0;
        #1;
        chk("post_addr", imem_addr, 32'h0);
        chk("post_req",  {31'd0, imem_req}, 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'h0;
        cyc();
        #1;
        chk("post_nopend", imem_addr, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
